// File: rtl/cpu_trace_emitter.sv
// ----------------------------------------------------------------------------
// cpu_trace_emitter
//
// Formats one CPU write event into an ASCII trace line and streams it out one
// character per valid/ready handshake:
//   register write : "^<time>@<pc>:<sp>$<reg><sp><=<sp><data>#"
//   memory write   : "^<time>@<pc>:<sp>*<addr><sp><=<sp><data>#"
// <sp> is SPACES blanks (0..7). Time is 4 BCD digits, reg is decimal, and
// pc/addr/data are 8 lowercase hex digits, most significant nibble first.
//
// Build option:
//   TRACE_ZPAD_EN  defined   -> time always 4 digits, reg always 2 digits
//                  undefined -> leading zeros suppressed (time 0 -> "0")
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset; aborts a line in flight
//   start      in   format one event (honoured only while ready=1)
//   kind       in   0 = register write, 1 = memory write
//   time_bcd   in   16-bit BCD time stamp, MS digit in [15:12]
//   pc         in   32-bit instruction address
//   reg_num    in   5-bit register index
//   mem_addr   in   32-bit memory address
//   wdata      in   32-bit written data
//   ready      out  1 while idle
//   out_valid  out  char/last are valid
//   out_ready  in   downstream accepts the character this cycle
//   char       out  ASCII character
//   last       out  high with the terminating '#'
//   err        out  one-cycle pulse when start is rejected for bad BCD
// ----------------------------------------------------------------------------
module cpu_trace_emitter #(
  parameter int SPACES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kind,
  input  logic [15:0] time_bcd,
  input  logic [31:0] pc,
  input  logic [4:0]  reg_num,
  input  logic [31:0] mem_addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  char,
  output logic        last,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_HAT, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_KIND,
    S_FIELD, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
  } state_t;

  localparam bit         LP_HAS_SP  = (SPACES != 0);
  // Index of the final blank in a space slot; meaningless when SPACES=0
  // because the slots are then bypassed entirely.
  localparam logic [2:0] LP_SP_LAST = 3'(SPACES - 1);

  // Presented character position: r_state names the field, r_cnt the digit
  // or blank within it.
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_valid;
  logic [7:0]  r_char;
  logic        r_last;
  logic        r_err;

  // Event snapshot taken at acceptance.
  logic        r_kind;
  logic [15:0] r_time;
  logic [31:0] r_pc;
  logic [4:0]  r_reg;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  logic        w_bcd_bad;
  logic        w_accept;
  logic [2:0]  w_t_start;
  logic [2:0]  w_r_start;
  logic [1:0]  w_tens;
  logic [3:0]  w_ones;
  logic        w_sp_done;
  logic        w_field_done;
  state_t      w_nxt_state;
  logic [2:0]  w_nxt_cnt;
  logic [7:0]  w_nxt_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    // 8'h57 + 10 = 'a'
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Digit i of an 8-digit word, i=0 being the most significant.
  function automatic logic [3:0] nib8(input logic [31:0] v, input logic [2:0] i);
    return v[{~i, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] nib4(input logic [15:0] v, input logic [1:0] i);
    return v[{~i, 2'b00} +: 4];
  endfunction

  assign ready     = (r_state == S_IDLE);
  assign out_valid = r_valid;
  assign char      = r_char;
  assign last      = r_last;
  assign err       = r_err;

  assign w_bcd_bad = (time_bcd[15:12] > 4'd9) || (time_bcd[11:8] > 4'd9) ||
                     (time_bcd[7:4]   > 4'd9) || (time_bcd[3:0]  > 4'd9);
  assign w_accept  = start && (r_state == S_IDLE) && !w_bcd_bad;

  assign w_sp_done    = (r_cnt == LP_SP_LAST);
  assign w_field_done = r_kind ? (r_cnt == 3'd7) : (r_cnt == 3'd1);

  // Decimal split of the latched register index.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    w_tens = 2'd0;
    w_ones = 4'(r_reg);
    if (r_reg >= 5'd30) begin
      w_tens = 2'd3;
      w_ones = 4'(r_reg - 5'd30);
    end else if (r_reg >= 5'd20) begin
      w_tens = 2'd2;
      w_ones = 4'(r_reg - 5'd20);
    end else if (r_reg >= 5'd10) begin
      w_tens = 2'd1;
      w_ones = 4'(r_reg - 5'd10);
    end
  end

  // First digit emitted for the time stamp and the register number.
`ifdef TRACE_ZPAD_EN
  assign w_t_start = 3'd0;
  assign w_r_start = 3'd0;
`else
  always_comb begin
    w_t_start = 3'd3;                  // all zero: emit the final "0" only
    if (r_time[15:12] != 4'd0)     w_t_start = 3'd0;
    else if (r_time[11:8] != 4'd0) w_t_start = 3'd1;
    else if (r_time[7:4] != 4'd0)  w_t_start = 3'd2;
  end
  assign w_r_start = (w_tens == 2'd0) ? 3'd1 : 3'd0;
`endif

  // Position that follows the one currently presented. Empty space slots
  // and suppressed leading digits are skipped here so that no zero-length
  // valid cycle is ever produced.
  always_comb begin
    w_nxt_state = S_IDLE;
    w_nxt_cnt   = 3'd0;
    unique case (r_state)
      S_IDLE:  w_nxt_state = S_HAT;
      S_HAT: begin
        w_nxt_state = S_TIME;
        w_nxt_cnt   = w_t_start;
      end
      S_TIME: begin
        if (r_cnt == 3'd3) begin
          w_nxt_state = S_AT;
        end else begin
          w_nxt_state = S_TIME;
          w_nxt_cnt   = r_cnt + 3'd1;
        end
      end
      S_AT:    w_nxt_state = S_PC;
      S_PC: begin
        if (r_cnt == 3'd7) begin
          w_nxt_state = S_COLON;
        end else begin
          w_nxt_state = S_PC;
          w_nxt_cnt   = r_cnt + 3'd1;
        end
      end
      S_COLON: w_nxt_state = LP_HAS_SP ? S_SP1 : S_KIND;
      S_SP1: begin
        if (w_sp_done) begin
          w_nxt_state = S_KIND;
        end else begin
          w_nxt_state = S_SP1;
          w_nxt_cnt   = r_cnt + 3'd1;
        end
      end
      S_KIND: begin
        w_nxt_state = S_FIELD;
        w_nxt_cnt   = r_kind ? 3'd0 : w_r_start;
      end
      S_FIELD: begin
        if (w_field_done) begin
          w_nxt_state = LP_HAS_SP ? S_SP2 : S_LT;
        end else begin
          w_nxt_state = S_FIELD;
          w_nxt_cnt   = r_cnt + 3'd1;
        end
      end
      S_SP2: begin
        if (w_sp_done) begin
          w_nxt_state = S_LT;
        end else begin
          w_nxt_state = S_SP2;
          w_nxt_cnt   = r_cnt + 3'd1;
        end
      end
      S_LT:    w_nxt_state = S_EQ;
      S_EQ:    w_nxt_state = LP_HAS_SP ? S_SP3 : S_DATA;
      S_SP3: begin
        if (w_sp_done) begin
          w_nxt_state = S_DATA;
        end else begin
          w_nxt_state = S_SP3;
          w_nxt_cnt   = r_cnt + 3'd1;
        end
      end
      S_DATA: begin
        if (r_cnt == 3'd7) begin
          w_nxt_state = S_HASH;
        end else begin
          w_nxt_state = S_DATA;
          w_nxt_cnt   = r_cnt + 3'd1;
        end
      end
      S_HASH:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Character at the next position, from the latched snapshot.
  always_comb begin
    w_nxt_char = 8'h00;
    unique case (w_nxt_state)
      S_HAT:   w_nxt_char = 8'h5e;                               // '^'
      S_TIME:  w_nxt_char = hex_char(nib4(r_time, w_nxt_cnt[1:0]));
      S_AT:    w_nxt_char = 8'h40;                               // '@'
      S_PC:    w_nxt_char = hex_char(nib8(r_pc, w_nxt_cnt));
      S_COLON: w_nxt_char = 8'h3a;                               // ':'
      S_SP1, S_SP2, S_SP3:
               w_nxt_char = 8'h20;
      S_KIND:  w_nxt_char = r_kind ? 8'h2a : 8'h24;              // '*' / '$'
      S_FIELD: begin
        if (r_kind)
          w_nxt_char = hex_char(nib8(r_addr, w_nxt_cnt));
        else if (w_nxt_cnt == 3'd0)
          w_nxt_char = 8'h30 + {6'h00, w_tens};
        else
          w_nxt_char = 8'h30 + {4'h0, w_ones};
      end
      S_LT:    w_nxt_char = 8'h3c;                               // '<'
      S_EQ:    w_nxt_char = 8'h3d;                               // '='
      S_DATA:  w_nxt_char = hex_char(nib8(r_data, w_nxt_cnt));
      S_HASH:  w_nxt_char = 8'h23;                               // '#'
      default: w_nxt_char = 8'h00;
    endcase
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_valid <= 1'b0;
      r_char  <= 8'h00;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          if (w_bcd_bad) begin
            r_err <= 1'b1;
          end else begin
            r_state <= S_HAT;
            r_cnt   <= 3'd0;
            r_valid <= 1'b1;
            r_char  <= 8'h5e;
            r_last  <= 1'b0;
          end
        end
      end else if (r_valid && out_ready) begin
        r_state <= w_nxt_state;
        r_cnt   <= w_nxt_cnt;
        if (r_state == S_HASH) begin
          r_valid <= 1'b0;
          r_char  <= 8'h00;
          r_last  <= 1'b0;
        end else begin
          r_char  <= w_nxt_char;
          r_last  <= (w_nxt_state == S_HASH);
        end
      end
    end
  end

  // Event snapshot.
  // NOTE: these are pure data holders qualified by the FSM, so they carry no
  // reset; their contents are never observed until a fresh start loads them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_kind <= kind;
      r_time <= time_bcd;
      r_pc   <= pc;
      r_reg  <= reg_num;
      r_addr <= mem_addr;
      r_data <= wdata;
    end
  end

endmodule
